etapa_if_id: RTL and testbench

Pipeline register and early decode between instruction fetch and register read. Captures the fetched instruction and PC+4 every cycle, splits the instruction into fields, and sign-extends the immediate. It decodes `beq`/`j` and returns them to fetch as `be`/`jump`/`j_address`. It also detects load-use hazards against the EX stage, stalling itself and requesting a bubble downstream.

---
 rtl/etapa_if_id_pkg.sv | 28 ++
 rtl/etapa_if_id_unidad_riesgos.sv | 18 +
 rtl/etapa_if_id.sv | 141 ++++++++++++++
 tb/tb_etapa_if_id.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/etapa_if_id_pkg.sv
// Shared constants for the IF/ID stage: opcodes, NOP encoding, field positions
// and the register update action.
package etapa_if_id_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [31:0] NOP      = 32'h0;

  // Instruction field positions (LSB of each field, MSB of the immediate)
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned JADDR_W    = 26;

  // What the pipeline register does on a non-reset posedge
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_LOAD
  } upd_e;

endpackage

// File: rtl/etapa_if_id_unidad_riesgos.sv
// Load-use hazard comparator: flags when the instruction in ID reads the
// register that the load currently in EX is about to write.
module unidad_riesgos (
  input  logic       valid_d,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hazard_stall
);

  // Register 0 is hard-wired, so a load targeting it never creates a hazard
  always_comb begin
    hazard_stall = valid_d & ex_mem_read & (ex_rt != 5'd0) &
                   ((ex_rt == rs) | (ex_rt == rt));
  end

endmodule

// File: rtl/etapa_if_id.sv
// IF/ID pipeline register with early decode (beq/j), immediate sign
// extension and load-use hazard detection.
// Optional statistics counters are built when IF_ID_STATS_EN is defined.
module etapa_if_id
  import etapa_if_id_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     instruction_f,
  input  logic [WIDTH-1:0]     pc_plus4_f,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rt,
  output logic [WIDTH-1:0]     instruction_d,
  output logic [WIDTH-1:0]     pc_plus4_d,
  output logic                 valid_d,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [WIDTH-1:0]     signal_extended,
  output logic [25:0]          j_address,
  output logic                 be,
  output logic                 jump,
  output logic                 hazard_stall,
  output logic                 bubble_d,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  logic [WIDTH-1:0] instruction_q, instruction_d_n;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d_n;
  logic             valid_q, valid_d_n;
  upd_e             upd;

  unidad_riesgos u_riesgos (
    .valid_d      (valid_q),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .rs           (rs),
    .rt           (rt),
    .hazard_stall (hazard_stall)
  );

  // Select the update action: flush beats hold beats load
  always_comb begin
    upd = UPD_LOAD;
    if (flush)                     upd = UPD_FLUSH;
    else if (stall | hazard_stall) upd = UPD_HOLD;
  end

  // Next contents of the pipeline register
  always_comb begin
    instruction_d_n = instruction_q;
    pc_plus4_d_n    = pc_plus4_q;
    valid_d_n       = valid_q;
    case (upd)
      UPD_FLUSH: begin
        instruction_d_n = WIDTH'(NOP);
        pc_plus4_d_n    = '0;
        valid_d_n       = 1'b0;
      end
      UPD_LOAD: begin
        instruction_d_n = instruction_f;
        pc_plus4_d_n    = pc_plus4_f;
        valid_d_n       = 1'b1;
      end
      default: ;
    endcase
  end

  // Pipeline register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instruction_q <= WIDTH'(NOP);
      pc_plus4_q    <= '0;
      valid_q       <= 1'b0;
    end else begin
      instruction_q <= instruction_d_n;
      pc_plus4_q    <= pc_plus4_d_n;
      valid_q       <= valid_d_n;
    end
  end

  // Field split, sign extension and early branch/jump decode
  always_comb begin
    instruction_d   = instruction_q;
    pc_plus4_d      = pc_plus4_q;
    valid_d         = valid_q;
    opcode          = instruction_q[OPCODE_LSB +: 6];
    rs              = instruction_q[RS_LSB +: 5];
    rt              = instruction_q[RT_LSB +: 5];
    rd              = instruction_q[RD_LSB +: 5];
    shamt           = instruction_q[SHAMT_LSB +: 5];
    funct           = instruction_q[FUNCT_LSB +: 6];
    j_address       = instruction_q[JADDR_W-1:0];
    signal_extended = {{(WIDTH-16){instruction_q[IMM_MSB]}}, instruction_q[IMM_MSB:0]};
    be              = valid_q & (opcode == OP_BEQ);
    jump            = valid_q & (opcode == OP_J);
    bubble_d        = hazard_stall | flush;
  end

`ifdef IF_ID_STATS_EN
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  // Saturating event counters for applied holds and flushes
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (upd == UPD_HOLD && stall_count_q != '1)
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    if (upd == UPD_FLUSH && flush_count_q != '1)
      flush_count_d = flush_count_q + CNT_WIDTH'(1);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_etapa_if_id.sv
// Randomized self-checking bench for etapa_if_id with an abstract reference
// model (contents + counters) and directed literal checks.
module tb_etapa_if_id;

  localparam int unsigned CW = 4;
`ifdef IF_ID_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instruction_f, pc_plus4_f;
  logic          flush, stall, ex_mem_read;
  logic [4:0]    ex_rt;
  logic [31:0]   instruction_d, pc_plus4_d, signal_extended;
  logic          valid_d, be, jump, hazard_stall, bubble_d;
  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [25:0]   j_address;
  logic [CW-1:0] stall_count, flush_count;

  etapa_if_id #(.WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_f(instruction_f), .pc_plus4_f(pc_plus4_f),
    .flush(flush), .stall(stall), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .instruction_d(instruction_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .signal_extended(signal_extended), .j_address(j_address), .be(be), .jump(jump),
    .hazard_stall(hazard_stall), .bubble_d(bubble_d),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          armed = 1'b0;

  // Reference model state
  logic [31:0] m_instr = '0, m_pc = '0;
  logic        m_valid = 1'b0;
  int unsigned m_scnt = 0, m_fcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    int unsigned r_s, r_t;
    r_s = (m_instr / 32'h0020_0000) % 32;
    r_t = (m_instr / 32'h0001_0000) % 32;
    return m_valid && ex_mem_read && ex_rt != 0 && (ex_rt == 5'(r_s) || ex_rt == 5'(r_t));
  endfunction

  task automatic check_all();
    int unsigned opc;
    int          imm;
    if (!armed) return;
    opc = m_instr / 32'h0400_0000;
    imm = int'($signed(m_instr[15:0]));
    chk("instruction_d", instruction_d, m_instr);
    chk("pc_plus4_d", pc_plus4_d, m_pc);
    chk("valid_d", 32'(valid_d), 32'(m_valid));
    chk("opcode", 32'(opcode), opc);
    chk("rs", 32'(rs), (m_instr >> 21) % 32);
    chk("rt", 32'(rt), (m_instr >> 16) % 32);
    chk("rd", 32'(rd), (m_instr >> 11) % 32);
    chk("shamt", 32'(shamt), (m_instr >> 6) % 32);
    chk("funct", 32'(funct), m_instr % 64);
    chk("signal_extended", signal_extended, 32'(imm));
    chk("j_address", 32'(j_address), m_instr % 32'h0400_0000);
    chk("be", 32'(be), 32'(m_valid && opc == 4));
    chk("jump", 32'(jump), 32'(m_valid && opc == 2));
    chk("hazard_stall", 32'(hazard_stall), 32'(m_hazard()));
    chk("bubble_d", 32'(bubble_d), 32'(m_hazard() || flush));
    chk("stall_count", 32'(stall_count), STATS ? m_scnt : 0);
    chk("flush_count", 32'(flush_count), STATS ? m_fcnt : 0);
  endtask

  // Apply inputs half a cycle ahead of the capture edge, then check
  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic st, input logic mr, input logic [4:0] ert);
    @(negedge clk);
    rst_n = r; instruction_f = ins; pc_plus4_f = pc;
    flush = fl; stall = st; ex_mem_read = mr; ex_rt = ert;
    #1 check_all();
  endtask

  // Capture edge: advance the model from the pre-edge state and inputs
  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = m_hazard();
    if (!rst_n) begin
      m_instr = '0; m_pc = '0; m_valid = 1'b0; m_scnt = 0; m_fcnt = 0;
      armed = 1'b1;
    end else if (flush) begin
      m_instr = '0; m_pc = '0; m_valid = 1'b0;
      if (m_fcnt < (1 << CW) - 1) m_fcnt++;
    end else if (stall || hz) begin
      if (m_scnt < (1 << CW) - 1) m_scnt++;
    end else begin
      m_instr = instruction_f; m_pc = pc_plus4_f; m_valid = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  ert;
    rst_n = 1'b0; instruction_f = '0; pc_plus4_f = '0;
    flush = 1'b0; stall = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;

    // Reset held two cycles
    drive(0, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0); tick();
    drive(0, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0); tick();
    chk("lit_reset_instr", instruction_d, 32'h0);
    chk("lit_reset_valid", 32'(valid_d), 32'h0);
    chk("lit_reset_be_jump", {30'h0, be, jump}, 32'h0);

    // lw r2, 4(r1)
    drive(1, 32'h8C220004, 32'h4, 0, 0, 0, 0); tick();
    chk("lit_lw_opcode", 32'(opcode), 32'h23);
    chk("lit_lw_rs", 32'(rs), 32'h1);
    chk("lit_lw_rt", 32'(rt), 32'h2);
    chk("lit_lw_imm", signal_extended, 32'h4);

    // beq with negative offset
    drive(1, 32'h1022FFFE, 32'h8, 0, 0, 0, 0); tick();
    chk("lit_beq_be", 32'(be), 32'h1);
    chk("lit_beq_imm", signal_extended, 32'hFFFFFFFE);

    // j then flush
    drive(1, 32'h08000010, 32'hC, 0, 0, 0, 0); tick();
    chk("lit_j_jump", 32'(jump), 32'h1);
    chk("lit_j_addr", 32'(j_address), 32'h10);
    drive(1, 32'h12345678, 32'h10, 1, 0, 0, 0); tick();
    chk("lit_flush_valid", 32'(valid_d), 32'h0);
    chk("lit_flush_jump", 32'(jump), 32'h0);
    chk("lit_flush_cnt", 32'(flush_count), STATS ? 32'h1 : 32'h0);

    // Load-use on rs=2
    drive(1, 32'h00430820, 32'h14, 0, 0, 0, 0); tick();
    drive(1, 32'h11111111, 32'h18, 0, 0, 1, 5'd2);
    chk("lit_lu_hazard", 32'(hazard_stall), 32'h1);
    chk("lit_lu_bubble", 32'(bubble_d), 32'h1);
    tick();
    chk("lit_lu_held", instruction_d, 32'h00430820);
    drive(1, 32'h00430820, 32'h1C, 0, 0, 1, 5'd0);
    chk("lit_rt0_nohazard", 32'(hazard_stall), 32'h0);
    tick();

    // Flush and hazard together
    drive(1, 32'h22222222, 32'h20, 1, 0, 1, 5'd2);
    chk("lit_fh_hazard", 32'(hazard_stall), 32'h1);
    tick();
    chk("lit_fh_valid", 32'(valid_d), 32'h0);
    chk("lit_fh_instr", instruction_d, 32'h0);
    chk("lit_fh_flush_cnt", 32'(flush_count), STATS ? 32'h2 : 32'h0);
    chk("lit_fh_stall_cnt", 32'(stall_count), STATS ? 32'h1 : 32'h0);

    // Stall saturation
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h33333333, 32'h24, 0, 1, 0, 0); tick();
    end
    chk("lit_stall_sat", 32'(stall_count), STATS ? 32'hF : 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: ins = {6'b100011, 26'($urandom)};
        1: ins = {6'b000100, 26'($urandom)};
        2: ins = {6'b000010, 26'($urandom)};
        default: ins = $urandom;
      endcase
      if ($urandom_range(1) == 1)
        ert = ($urandom_range(1) == 1) ? m_instr[25:21] : m_instr[20:16];
      else
        ert = 5'($urandom);
      drive(($urandom_range(49) != 0), ins, $urandom,
            ($urandom_range(7) == 0), ($urandom_range(5) == 0),
            ($urandom_range(2) == 0), ert);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
